// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the uart_rx receive buffer.
// Optional level reporting is enabled by defining UART_RX_FIFO_LEVEL_EN.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream bundle: uart_rx-style strobe on the input side, valid/ready on the output side.
// Handshake: a byte moves out when out_valid and out_ready are both high at a rising clk edge.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module uart_rx_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind uart_rx with sticky overflow flag.
// Define UART_RX_FIFO_LEVEL_EN to add the level and almost_full outputs.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
`ifdef UART_RX_FIFO_LEVEL_EN
    parameter int ALMOST_FULL = 12,
`endif
    parameter int DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_rx_fifo_if.slave          bus,
    output logic                   overflow,
`ifdef UART_RX_FIFO_LEVEL_EN
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
`endif
    input  logic                   overflow_clear
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_next, rd_next;
    logic          empty, full;
    logic          push, pop, drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = !empty && bus.out_ready;
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    always_comb begin
        wr_next = wr_ptr;
        rd_next = rd_ptr;
        if (push) wr_next = wr_ptr + 1'b1;
        if (pop)  rd_next = rd_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (bus.out_data)
    );

    assign bus.out_valid = !empty;

`ifdef UART_RX_FIFO_LEVEL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else begin
            level <= wr_next - rd_next;
        end
    end

    assign almost_full = (32'(level) >= ALMOST_FULL);
`endif
endmodule
